comp_serial_nbit: RTL and testbench

COMP_SERIAL_NBIT -- requirements
Module: comp_serial_nbit

---
 rtl/comp_serial_nbit_if.sv | 23 ++
 rtl/comp_serial_nbit.sv | 101 ++++++++++
 tb/tb_comp_serial_nbit.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/comp_serial_nbit_if.sv
// Handshake and operand/result bundle for the bit-serial magnitude comparator.
interface comp_serial_nbit_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             Eq;
    logic             Le;
    logic             Gt;

    modport master (
        output start, A, B,
        input  busy, done, Eq, Le, Gt
    );

    modport slave (
        input  start, A, B,
        output busy, done, Eq, Le, Gt
    );
endinterface

// File: rtl/comp_serial_nbit.sv
// Bit-serial unsigned comparator: scans operands MSB first, stopping at the first differing bit.
module comp_serial_nbit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    comp_serial_nbit_if.slave   bus
);
    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [WIDTH-1:0] a_r, a_n;
    logic [WIDTH-1:0] b_r, b_n;
    logic             busy_q, busy_n;
    logic             done_q, done_n;
    logic             eq_q, eq_n;
    logic             le_q, le_n;
    logic             gt_q, gt_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= IDX_MSB;
            a_r    <= '0;
            b_r    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            eq_q   <= 1'b0;
            le_q   <= 1'b0;
            gt_q   <= 1'b0;
        end else begin
            state  <= state_n;
            idx    <= idx_n;
            a_r    <= a_n;
            b_r    <= b_n;
            busy_q <= busy_n;
            done_q <= done_n;
            eq_q   <= eq_n;
            le_q   <= le_n;
            gt_q   <= gt_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        a_n     = a_r;
        b_n     = b_r;
        busy_n  = busy_q;
        done_n  = 1'b0;
        eq_n    = eq_q;
        le_n    = le_q;
        gt_n    = gt_q;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    a_n     = bus.A;
                    b_n     = bus.B;
                    idx_n   = IDX_MSB;
                    eq_n    = 1'b0;
                    le_n    = 1'b0;
                    gt_n    = 1'b0;
                    busy_n  = 1'b1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                // First differing bit from the top decides; equal bits walk down to bit 0.
                if (a_r[idx] && !b_r[idx]) begin
                    gt_n    = 1'b1;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else if (!a_r[idx] && b_r[idx]) begin
                    le_n    = 1'b1;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else if (idx == '0) begin
                    eq_n    = 1'b1;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else begin
                    idx_n = idx - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.Eq   = eq_q;
    assign bus.Le   = le_q;
    assign bus.Gt   = gt_q;
endmodule

// File: tb/tb_comp_serial_nbit.sv
// Directed bench for comp_serial_nbit at WIDTH=8; outputs sampled on the falling clock edge.
module tb_comp_serial_nbit;
    localparam int unsigned WIDTH = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    comp_serial_nbit_if #(.WIDTH(WIDTH)) bus ();

    comp_serial_nbit #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [2:0] flags();
        return {bus.Eq, bus.Le, bus.Gt};
    endfunction

    // Starts a compare from the current falling edge and follows it to its done cycle.
    task automatic compare(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input int k, input logic [2:0] exp_flags);
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check({tag, "_accept_busy"}, 32'(bus.busy), 32'd1);
        check({tag, "_accept_flags"}, 32'(flags()), 32'd0);
        for (int n = 1; n <= k; n++) begin
            step();
            check($sformatf("%s_done_c%0d", tag, n), 32'(bus.done), 32'(n == k));
            check($sformatf("%s_busy_c%0d", tag, n), 32'(bus.busy), 32'(n != k));
        end
        check({tag, "_flags"}, 32'(flags()), 32'(exp_flags));
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        step();
        step();
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_flags", 32'(flags()), 32'd0);
        rst = 1'b0;
        step();
        check("idle_done", 32'(bus.done), 32'd0);

        // Equal operands walk all 8 bits; flag order is {Eq,Le,Gt}.
        compare("eq5a", 8'h5A, 8'h5A, 8, 3'b100);
        step();
        check("eq5a_done_low", 32'(bus.done), 32'd0);
        check("eq5a_hold", 32'(flags()), 32'd4);

        compare("gt80", 8'h80, 8'h7F, 1, 3'b001);
        step();
        check("gt80_done_low", 32'(bus.done), 32'd0);
        check("gt80_hold", 32'(flags()), 32'd1);

        // Bit 3 differs: done after 5 cycles, second start and operand changes ignored.
        bus.A     = 8'h3C;
        bus.B     = 8'h34;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("gt3c_accept_busy", 32'(bus.busy), 32'd1);
        check("gt3c_accept_flags", 32'(flags()), 32'd0);
        for (int n = 1; n <= 5; n++) begin
            if (n == 2) begin
                bus.start = 1'b1;
                bus.A     = 8'h00;
                bus.B     = 8'hFF;
            end else begin
                bus.start = 1'b0;
            end
            step();
            check($sformatf("gt3c_done_c%0d", n), 32'(bus.done), 32'(n == 5));
            check($sformatf("gt3c_busy_c%0d", n), 32'(bus.busy), 32'(n != 5));
        end
        bus.start = 1'b0;
        check("gt3c_flags", 32'(flags()), 32'd1);
        step();
        check("gt3c_done_low", 32'(bus.done), 32'd0);
        check("gt3c_busy_low", 32'(bus.busy), 32'd0);

        // Abort mid-compare with an asynchronous reset.
        bus.A     = 8'h00;
        bus.B     = 8'h00;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int n = 1; n <= 3; n++) step();
        check("abort_busy_before", 32'(bus.busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_flags", 32'(flags()), 32'd0);
        step();
        step();
        rst = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            step();
            check($sformatf("abort_nodone_c%0d", n), 32'(bus.done), 32'd0);
        end
        compare("gt01", 8'h01, 8'h00, 8, 3'b001);
        step();
        check("gt01_done_low", 32'(bus.done), 32'd0);

        // Back-to-back: second start issued in the done cycle of the first.
        compare("le12", 8'h12, 8'h13, 8, 3'b010);
        compare("gtff", 8'hFF, 8'hFE, 8, 3'b001);
        step();
        check("gtff_done_low", 32'(bus.done), 32'd0);
        check("gtff_hold", 32'(flags()), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
